// File: rtl/fft_pkg.sv
// Shared FFT constants, readout state encoding and the 6-bit bit-reversal
// used by both the butterfly address generator and the output sequencer.
package fft_pkg;

  localparam int N      = 64;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] bitrev6(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/output_counter_if.sv
// Result-memory read port plus the natural-order result stream.
// Handshake: a word transfers on any cycle with outvalid && outready; outvalid never
// depends on outready, and out_data_o/index_o hold steady while outvalid is high and
// outready is low.
interface output_counter_if #(
  parameter int DATA_W = 32
);
  import fft_pkg::*;

  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic [DATA_W-1:0] out_data_o;
  logic              outvalid;
  logic              outready;
  logic [ADDR_W-1:0] index_o;
  logic              outlast;

  modport master (
    output rd_en_o, rd_addr_o, out_data_o, outvalid, index_o, outlast,
    input  rd_data_i, outready
  );

  modport slave (
    input  rd_en_o, rd_addr_o, out_data_o, outvalid, index_o, outlast,
    output rd_data_i, outready
  );

endinterface

// File: rtl/bit_reverse.sv
// Pure wire swap: reverses the bit order of a 6-bit index.
module bit_reverse
  import fft_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] y
);

  assign y = bitrev6(a);

endmodule

// File: rtl/output_counter.sv
// Readout sequencer: walks the FFT result memory in bit-reversed order and streams
// the 64 results in natural order, with early-warning and end-of-frame pulses.
module output_counter
  import fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EARLY  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              outstart,
  output_counter_if.master  bus,
  output logic              almostdone,
  output logic              busy,
  output logic              doneflag,
  output state_t            state_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ALMOST_IDX = ADDR_W'(N - 1 - EARLY);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_idx, fetch_nxt;
  logic [ADDR_W-1:0] out_idx, out_nxt;
  logic [ADDR_W-1:0] rd_addr_q, addr_nxt;
  logic              rd_en;
  logic              xfer;
  logic              valid;
  logic [DATA_W-1:0] data_gated;

  // The read address always tracks bitrev(fetch_idx), so it is computed from the
  // next fetch index and registered alongside it.
  bit_reverse u_bit_reverse (
    .a (fetch_nxt),
    .y (addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_idx <= '0;
      out_idx   <= '0;
      rd_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      fetch_idx <= fetch_nxt;
      out_idx   <= out_nxt;
      rd_addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_idx;
    out_nxt   = out_idx;
    rd_en     = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (outstart) begin
          state_nxt = FETCH;
          fetch_nxt = '0;
          out_nxt   = '0;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        fetch_nxt = fetch_idx + 6'd1;
        state_nxt = STREAM;
      end
      STREAM: begin
        xfer = bus.outready;
        // fetch_idx wraps to 0 once index 63 has been issued; no 65th read.
        rd_en = bus.outready && (fetch_idx != '0);
        if (rd_en) begin
          fetch_nxt = fetch_idx + 6'd1;
        end
        if (xfer) begin
          out_nxt = out_idx + 6'd1;
          if (out_idx == LAST_IDX) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign valid      = (state == STREAM);
  assign data_gated = valid ? bus.rd_data_i : '0;

  assign bus.rd_en_o    = rd_en;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.out_data_o = data_gated;
  assign bus.outvalid   = valid;
  assign bus.index_o    = out_idx;
  assign bus.outlast    = valid && (out_idx == LAST_IDX);

  assign almostdone = xfer && (out_idx == ALMOST_IDX);
  assign busy       = (state != IDLE);
  assign doneflag   = (state == DONE);
  assign state_o    = state;

endmodule
